id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch unit. Holds the IF/ID
//  register, the 32x32 GRF, hazard detection and ID-stage branch resolution (one delay slot, no flush).
//  Returns branch/jump control and stall to fetch; presents decoded operands to the EX-side ID/EX register.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC held in IF/ID after reset
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  if_ins       in   32  instruction fetched this cycle
//  if_pc        in   32  PC of if_ins
//  ex_wr_en     in   1   instruction in EX writes a GPR
//  ex_wr_addr   in   5   its destination
//  ex_is_load   in   1   instruction in EX is lw
//  mem_wr_en    in   1   instruction in MEM writes a GPR
//  mem_wr_addr  in   5   its destination
//  mem_wr_data  in   32  its ALU result (invalid if mem_is_load)
//  mem_is_load  in   1   instruction in MEM is lw
//  w_en         in   1   writeback enable
//  w_addr       in   5   writeback register
//  w_data       in   32  writeback data
//  ifu_we       out  1   fetch PC/IF-ID enable (0 = stall)
//  br           out  1   beq in ID
//  zero         out  1   beq operands equal
//  jal          out  1   jal in ID
//  jr           out  1   jr in ID
//  ra           out  32  jr target (forwarded rs value)
//  imm16        out  16  ins[15:0] to fetch
//  addr26       out  26  ins[25:0] to fetch
//  id_valid     out  1   0 = bubble into ID/EX
//  id_ins       out  32  instruction in ID
//  id_pc        out  32  its PC; id_pc8 = id_pc+8 (link value)
//  id_pc8       out  32  id_pc + 8
//  rs_data      out  32  forwarded GPR[rs]
//  rt_data      out  32  forwarded GPR[rt]
//  ext_imm      out  32  sign-ext imm16 (zero-ext for ori/andi/lui)
// BEHAVIOUR
//  - IF/ID reg: reset -> ins=0 (nop), pc=RESET_PC. Loads if_ins/if_pc each edge when ifu_we=1, holds when 0.
//  - GRF: reset clears all 32 regs. Write at edge when w_en && w_addr!=0; $0 always reads 0.
//    Same-cycle write-through: read of w_addr (!=0) while w_en returns w_data.
//  - Operand select (rs, rt independently, reg!=0): MEM match && !mem_is_load -> mem_wr_data; else GRF/bypass.
//  - Decode: beq op=000100; jal op=000011; jr op=0 funct=001000. reads_rs/reads_rt per opcode.
//    Instr with no GPR read never stalls.
//  - stall=1 when ID reads r!=0 and any of:
//    (a) ex_wr_en && ex_wr_addr==r && ex_is_load;
//    (b) ID is beq/jr && ex_wr_en && ex_wr_addr==r;
//    (c) ID is beq/jr && mem_wr_en && mem_wr_addr==r && mem_is_load.
//  - ifu_we = ~stall; id_valid = ~stall; br/jal/jr forced 0 while stall. Outputs combinational from
//    IF/ID + GRF, so latency fetch->ID outputs = 1 cycle.
//  - zero = (rs_data==rt_data), 32-bit compare. ra = rs_data. Branch target math stays in fetch (delay slot).
//  - After reset: id_valid=1 with nop, br=jal=jr=0, ifu_we=1, rs_data=rt_data=0.
//  - Reset mid-stall: reset wins; IF/ID reloads nop/RESET_PC and the stall clears next cycle.
//  - Stall persists while its condition holds; no limit.
// TESTING
//  1 reset, stream addu/ori -> IF/ID follows if_ins at 1-cycle lag, ifu_we=1, id_pc=3000,3004...
//  2 EX lw $8 (ex_is_load=1), ID addu $9,$8,$8 -> 1 cycle ifu_we=0,id_valid=0, IF/ID held; then proceeds.
//  3 ID beq $4,$5,+3; MEM ALU writes $4=7; GRF $5=7 -> br=1,zero=1,imm16=3, no stall.
//  4 ID beq $4,$0; EX ALU writes $4 -> 1-cycle stall, then br=1 with MEM-forwarded compare.
//  5 write $0=5 -> reads 0; w_en $6=0xABCD while ID reads $6 -> rs_data=0xABCD same cycle.
//  6 ID jr $31, w_en $31=0x3010 same cycle -> jr=1, ra=0x3010; assert reset mid-stall -> nop at 3000.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file with write-through,
// MEM-stage operand forwarding, load/branch hazard detection and
// ID-stage resolution of beq/jal/jr (one delay slot, no flush).
module id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_ins,
   input  logic [31:0] if_pc,
   input  logic        ex_wr_en,
   input  logic [4:0]  ex_wr_addr,
   input  logic        ex_is_load,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_wr_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_is_load,
   input  logic        w_en,
   input  logic [4:0]  w_addr,
   input  logic [31:0] w_data,
   output logic        ifu_we,
   output logic        br,
   output logic        zero,
   output logic        jal,
   output logic        jr,
   output logic [31:0] ra,
   output logic [15:0] imm16,
   output logic [25:0] addr26,
   output logic        id_valid,
   output logic [31:0] id_ins,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic [31:0] ext_imm
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   logic [31:0] ins_q, ins_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [32];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        is_beq;
   logic        is_jal;
   logic        is_jr;
   logic        reads_rs;
   logic        reads_rt;
   logic        stall;

   assign op    = ins_q[31:26];
   assign funct = ins_q[5:0];
   assign rs    = ins_q[25:21];
   assign rt    = ins_q[20:16];

   // Register read: $0 is hardwired, MEM-stage ALU result has priority,
   // then a same-cycle writeback, then the stored value.
   function automatic logic [31:0] read_reg(input logic [4:0] r);
      logic [31:0] v;
      if (r == 5'd0)
         v = '0;
      else if (mem_wr_en && (mem_wr_addr == r) && !mem_is_load)
         v = mem_wr_data;
      else if (w_en && (w_addr == r))
         v = w_data;
      else
         v = regs_q[r];
      return v;
   endfunction

   // A source register is not yet available: a load in EX always blocks,
   // and beq/jr compare in ID so they also wait on an ALU result in EX
   // and on a load in MEM.
   function automatic logic hazard(input logic [4:0] r, input logic used,
                                   input logic resolves_in_id);
      logic h;
      h = 1'b0;
      if (used && (r != 5'd0)) begin
         if (ex_wr_en && (ex_wr_addr == r) && ex_is_load)
            h = 1'b1;
         if (resolves_in_id && ex_wr_en && (ex_wr_addr == r))
            h = 1'b1;
         if (resolves_in_id && mem_wr_en && (mem_wr_addr == r) && mem_is_load)
            h = 1'b1;
      end
      return h;
   endfunction

   // Instruction class decode and which GPR fields are actually read.
   always_comb begin
      is_beq   = (op == OP_BEQ);
      is_jal   = (op == OP_JAL);
      is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
      reads_rs = 1'b0;
      reads_rt = 1'b0;
      case (op)
         OP_RTYPE: begin
            reads_rs = 1'b1;
            reads_rt = (funct != FN_JR);
         end
         OP_BEQ, OP_BNE, OP_SW: begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
         end
         OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
            reads_rs = 1'b1;
         end
         default: begin
            reads_rs = 1'b0;
            reads_rt = 1'b0;
         end
      endcase
   end

   // Stall and the control/operand outputs presented to fetch and EX.
   always_comb begin
      stall    = hazard(rs, reads_rs, is_beq | is_jr)
               | hazard(rt, reads_rt, is_beq | is_jr);
      ifu_we   = ~stall;
      id_valid = ~stall;
      br       = is_beq & ~stall;
      jal      = is_jal & ~stall;
      jr       = is_jr  & ~stall;
      rs_data  = read_reg(rs);
      rt_data  = read_reg(rt);
      zero     = (rs_data == rt_data);
      ra       = rs_data;
      imm16    = ins_q[15:0];
      addr26   = ins_q[25:0];
      id_ins   = ins_q;
      id_pc    = pc_q;
      id_pc8   = pc_q + 32'd8;
      if ((op == OP_ORI) || (op == OP_ANDI) || (op == OP_LUI))
         ext_imm = {16'h0000, ins_q[15:0]};
      else
         ext_imm = {{16{ins_q[15]}}, ins_q[15:0]};
   end

   // IF/ID next state: load from fetch unless stalled.
   always_comb begin
      ins_d = ins_q;
      pc_d  = pc_q;
      if (ifu_we) begin
         ins_d = if_ins;
         pc_d  = if_pc;
      end
   end

   // IF/ID register; reset installs a nop at the reset PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         ins_q <= '0;
         pc_q  <= RESET_PC;
      end else begin
         ins_q <= ins_d;
         pc_q  <= pc_d;
      end
   end

   // Register file write port; writes to $0 are discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++)
            regs_q[i] <= '0;
      end else if (w_en && (w_addr != 5'd0)) begin
         regs_q[w_addr] <= w_data;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: each cycle the expected ID-stage outputs
// are queued when stimulus is driven and popped/compared at the falling edge.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_ins, if_pc;
   logic        ex_wr_en, ex_is_load;
   logic [4:0]  ex_wr_addr;
   logic        mem_wr_en, mem_is_load;
   logic [4:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        ifu_we, br, zero, jal, jr, id_valid;
   logic [31:0] ra, id_ins, id_pc, id_pc8, rs_data, rt_data, ext_imm;
   logic [15:0] imm16;
   logic [25:0] addr26;

   id_stage #(.RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .if_ins(if_ins), .if_pc(if_pc),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_is_load(mem_is_load), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .ifu_we(ifu_we), .br(br), .zero(zero), .jal(jal), .jr(jr), .ra(ra),
      .imm16(imm16), .addr26(addr26), .id_valid(id_valid), .id_ins(id_ins),
      .id_pc(id_pc), .id_pc8(id_pc8), .rs_data(rs_data), .rt_data(rt_data),
      .ext_imm(ext_imm)
   );

   always #5 clk = ~clk;

   typedef enum int unsigned {
      S_WE, S_VALID, S_BR, S_ZERO, S_JAL, S_JR, S_RA, S_IMM16, S_ADDR26,
      S_INS, S_PC, S_PC8, S_RS, S_RT, S_EXT
   } sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_WE:     return {31'd0, ifu_we};
         S_VALID:  return {31'd0, id_valid};
         S_BR:     return {31'd0, br};
         S_ZERO:   return {31'd0, zero};
         S_JAL:    return {31'd0, jal};
         S_JR:     return {31'd0, jr};
         S_RA:     return ra;
         S_IMM16:  return {16'd0, imm16};
         S_ADDR26: return {6'd0, addr26};
         S_INS:    return id_ins;
         S_PC:     return id_pc;
         S_PC8:    return id_pc8;
         S_RS:     return rs_data;
         S_RT:     return rt_data;
         default:  return ext_imm;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic settle();
      exp_t e;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] pc);
      if_ins = ins;
      if_pc  = pc;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   logic [31:0] i_ori, i_addu2, i_lw, i_addu9, i_beq45, i_beq40, i_addu0, i_addu76,
                i_addu706, i_jr31, i_jal;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      i_ori     = enc_i(6'h0d, 5'd0, 5'd1, 16'h8001);
      i_addu2   = enc_r(5'd1, 5'd1, 5'd2, 6'h21);
      i_lw      = enc_i(6'h23, 5'd0, 5'd3, 16'hFFFC);
      i_addu9   = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
      i_beq45   = enc_i(6'h04, 5'd4, 5'd5, 16'd3);
      i_beq40   = enc_i(6'h04, 5'd4, 5'd0, 16'd5);
      i_addu0   = enc_r(5'd0, 5'd0, 5'd11, 6'h21);
      i_addu76  = enc_r(5'd6, 5'd0, 5'd7, 6'h21);
      i_addu706 = enc_r(5'd0, 5'd6, 5'd7, 6'h21);
      i_jr31    = {6'd0, 5'd31, 15'd0, 6'h08};
      i_jal     = {6'h03, 26'h0000C04};

      reset = 1'b1;
      if_ins = '0; if_pc = '0;
      ex_wr_en = 0; ex_wr_addr = '0; ex_is_load = 0;
      mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0; mem_is_load = 0;
      w_en = 0; w_addr = '0; w_data = '0;

      // Reset state
      @(posedge clk);
      step(32'hFFFF_FFFF, 32'h0000_1234);
      push_exp("rst_ins", S_INS, 32'h0);
      push_exp("rst_pc", S_PC, 32'h3000);
      push_exp("rst_we", S_WE, 1);
      push_exp("rst_valid", S_VALID, 1);
      push_exp("rst_br", S_BR, 0);
      push_exp("rst_jal", S_JAL, 0);
      push_exp("rst_jr", S_JR, 0);
      push_exp("rst_rs", S_RS, 0);
      push_exp("rst_rt", S_RT, 0);
      settle();
      reset = 1'b0;

      // Straight-line stream follows fetch with one cycle of lag
      step(i_ori, 32'h3000);
      push_exp("s1_ins", S_INS, i_ori);
      push_exp("s1_pc", S_PC, 32'h3000);
      push_exp("s1_pc8", S_PC8, 32'h3008);
      push_exp("s1_ext_zero", S_EXT, 32'h0000_8001);
      push_exp("s1_we", S_WE, 1);
      settle();
      step(i_addu2, 32'h3004);
      push_exp("s1_ins2", S_INS, i_addu2);
      push_exp("s1_pc2", S_PC, 32'h3004);
      push_exp("s1_rs2", S_RS, 0);
      settle();
      step(i_lw, 32'h3008);
      push_exp("s1_ext_sign", S_EXT, 32'hFFFF_FFFC);
      push_exp("s1_pc3", S_PC, 32'h3008);
      settle();

      // Load-use stall on addu $9,$8,$8
      step(i_addu9, 32'h300C);
      ex_wr_en = 1; ex_wr_addr = 5'd8; ex_is_load = 1;
      push_exp("s2_stall_we", S_WE, 0);
      push_exp("s2_stall_valid", S_VALID, 0);
      push_exp("s2_stall_ins", S_INS, i_addu9);
      settle();
      step(32'h0, 32'h3010);
      ex_wr_en = 0; ex_is_load = 0;
      mem_wr_en = 1; mem_wr_addr = 5'd8; mem_wr_data = 32'hDEAD_BEEF; mem_is_load = 1;
      w_en = 1; w_addr = 5'd5; w_data = 32'd7;
      push_exp("s2_held_ins", S_INS, i_addu9);
      push_exp("s2_held_pc", S_PC, 32'h300C);
      push_exp("s2_go_we", S_WE, 1);
      push_exp("s2_go_valid", S_VALID, 1);
      push_exp("s2_noload_fwd", S_RS, 0);
      settle();
      step(32'h0, 32'h3010);
      mem_wr_en = 0; mem_is_load = 0; w_en = 0;
      push_exp("s2_next_pc", S_PC, 32'h3010);
      settle();

      // beq with MEM-forwarded rs and GRF rt, no stall
      step(i_beq45, 32'h3014);
      mem_wr_en = 1; mem_wr_addr = 5'd4; mem_wr_data = 32'd7; mem_is_load = 0;
      push_exp("s3_br", S_BR, 1);
      push_exp("s3_zero", S_ZERO, 1);
      push_exp("s3_imm16", S_IMM16, 32'd3);
      push_exp("s3_we", S_WE, 1);
      push_exp("s3_rs", S_RS, 32'd7);
      push_exp("s3_rt", S_RT, 32'd7);
      settle();

      // beq waits one cycle on an ALU result in EX
      step(i_beq40, 32'h3018);
      mem_wr_en = 0;
      ex_wr_en = 1; ex_wr_addr = 5'd4; ex_is_load = 0;
      push_exp("s4_stall_we", S_WE, 0);
      push_exp("s4_stall_valid", S_VALID, 0);
      push_exp("s4_stall_br", S_BR, 0);
      settle();
      step(32'h0, 32'h301C);
      ex_wr_en = 0;
      mem_wr_en = 1; mem_wr_addr = 5'd4; mem_wr_data = 32'h55; mem_is_load = 0;
      w_en = 1; w_addr = 5'd0; w_data = 32'd5;
      push_exp("s4_br", S_BR, 1);
      push_exp("s4_zero", S_ZERO, 0);
      push_exp("s4_rs_fwd", S_RS, 32'h55);
      push_exp("s4_pc", S_PC, 32'h3018);
      push_exp("s4_we", S_WE, 1);
      settle();

      // $0 stays zero; write-through of $6
      step(i_addu0, 32'h301C);
      mem_wr_en = 0; w_en = 0;
      push_exp("s5_r0_rs", S_RS, 0);
      push_exp("s5_r0_rt", S_RT, 0);
      settle();
      step(i_addu76, 32'h3020);
      w_en = 1; w_addr = 5'd6; w_data = 32'h0000_ABCD;
      push_exp("s5_wthru", S_RS, 32'h0000_ABCD);
      settle();
      step(i_addu706, 32'h3024);
      w_en = 0;
      push_exp("s5_stored", S_RT, 32'h0000_ABCD);
      settle();

      // jr with same-cycle writeback of $31, then jal
      step(i_jr31, 32'h3028);
      w_en = 1; w_addr = 5'd31; w_data = 32'h3010;
      push_exp("s6_jr", S_JR, 1);
      push_exp("s6_ra", S_RA, 32'h3010);
      push_exp("s6_we", S_WE, 1);
      push_exp("s6_br", S_BR, 0);
      settle();
      step(i_jal, 32'h302C);
      w_en = 0;
      push_exp("s6_jal", S_JAL, 1);
      push_exp("s6_addr26", S_ADDR26, 32'h0000_0C04);
      push_exp("s6_pc8", S_PC8, 32'h3034);
      push_exp("s6_jal_jr", S_JR, 0);
      settle();

      // jr stalled on EX writer of $31, then reset while stalled
      step(i_jr31, 32'h3030);
      ex_wr_en = 1; ex_wr_addr = 5'd31; ex_is_load = 0;
      push_exp("s6_stall_jr", S_JR, 0);
      push_exp("s6_stall_we", S_WE, 0);
      push_exp("s6_stall_valid", S_VALID, 0);
      settle();
      reset = 1'b1;
      step(i_addu2, 32'h3034);
      reset = 1'b0;
      push_exp("s6_rst_ins", S_INS, 32'h0);
      push_exp("s6_rst_pc", S_PC, 32'h3000);
      push_exp("s6_rst_we", S_WE, 1);
      push_exp("s6_rst_valid", S_VALID, 1);
      settle();
      ex_wr_en = 0;
      step(i_ori, 32'h3000);
      push_exp("s6_after_ins", S_INS, i_ori);
      push_exp("s6_after_rs", S_RS, 0);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
